// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared helpers for the VGA timing generator
// Purpose: prescaler width sizing and sync polarity mapping.
// Ports:   none (package).
package vga_timing_gen_pkg;

  // A divide-by-1 prescaler still needs a 1-bit register to stay legal.
  function automatic int presc_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Map "inside sync window" onto the configured pin level.
  function automatic logic sync_level(input logic in_sync, input logic pol);
    return in_sync ? pol : ~pol;
  endfunction

endpackage

// File: rtl/timing_axis_cnt.sv
// rtl/timing_axis_cnt.sv - one raster axis: wrap counter with registered sync/active decode
// Purpose: counts 0..TOTAL-1 on inc, flags the wrap, and registers sync/active
//          decoded from the next count so they line up with cnt.
// Ports:   clk, reset (sync, active-high), en (decode update enable), inc (advance),
//          cnt [WIDTH-1:0], wrap (comb, inc at TOTAL-1), in_sync, active.
module timing_axis_cnt
  import vga_timing_gen_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752,
  parameter int ACTIVE     = 640
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             in_sync,
  output logic             active
);

  // Bounds are one bit wider so SYNC_END may equal 2**WIDTH without truncating.
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH:0]   S_START = (WIDTH + 1)'(SYNC_START);
  localparam logic [WIDTH:0]   S_END   = (WIDTH + 1)'(SYNC_END);
  localparam logic [WIDTH:0]   ACT     = (WIDTH + 1)'(ACTIVE);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sync_q, sync_d;
  logic             active_q, active_d;
  logic [WIDTH:0]   cnt_ext;

  always_comb begin
    wrap     = inc && (cnt_q == LAST);
    cnt_d    = cnt_q;
    sync_d   = sync_q;
    active_d = active_q;
    if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
    end
    cnt_ext = {1'b0, cnt_d};
    // Decoding the next count keeps sync/active in step with cnt; holding
    // while disabled keeps the post-reset idle levels until counting starts.
    if (en) begin
      sync_d   = (cnt_ext >= S_START) && (cnt_ext < S_END);
      active_d = (cnt_ext < ACT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      sync_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

  assign cnt     = cnt_q;
  assign in_sync = sync_q;
  assign active  = active_q;

endmodule

// File: rtl/vga_timing_defs.vh
// rtl/vga_timing_defs.vh - default 640x480@60 timing constants and axis bound formulas
// Purpose: shared defaults for the raster generator plus the formulas that turn
//          active/porch/sync widths into total, sync-start and sync-end positions.
// Ports:   none (macros only).
`ifndef VGA_TIMING_DEFS_VH
`define VGA_TIMING_DEFS_VH

`define VGA_DEF_CLK_DIV   2
`define VGA_DEF_H_ACTIVE  640
`define VGA_DEF_H_FP      16
`define VGA_DEF_H_SYNC    96
`define VGA_DEF_H_BP      48
`define VGA_DEF_V_ACTIVE  480
`define VGA_DEF_V_FP      10
`define VGA_DEF_V_SYNC    2
`define VGA_DEF_V_BP      33

`define VGA_TOTAL(act, fp, sy, bp)  ((act) + (fp) + (sy) + (bp))
`define VGA_SYNC_START(act, fp)     ((act) + (fp))
`define VGA_SYNC_END(act, fp, sy)   ((act) + (fp) + (sy))

`endif

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
// Purpose: prescales Clk into a pixel tick and drives horizontal/vertical axis
//          counters, syncs, the active-video window and line/frame pulses.
// Ports:   Clk, Reset (sync, active-high), En (count enable),
//          pixel_x/pixel_y [CNT_W-1:0], pixel_tick, hsync, vsync, video_on,
//          line_end, frame_end.
`include "vga_timing_defs.vh"

module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV  = `VGA_DEF_CLK_DIV,
  parameter int H_ACTIVE = `VGA_DEF_H_ACTIVE,
  parameter int H_FP     = `VGA_DEF_H_FP,
  parameter int H_SYNC   = `VGA_DEF_H_SYNC,
  parameter int H_BP     = `VGA_DEF_H_BP,
  parameter int V_ACTIVE = `VGA_DEF_V_ACTIVE,
  parameter int V_FP     = `VGA_DEF_V_FP,
  parameter int V_SYNC   = `VGA_DEF_V_SYNC,
  parameter int V_BP     = `VGA_DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             pixel_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_end,
  output logic             frame_end
);

  localparam int H_TOTAL = `VGA_TOTAL(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = `VGA_TOTAL(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int PW      = presc_w(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          line_end_q, line_end_d;
  logic          frame_end_q, frame_end_d;
  logic          h_wrap, v_wrap, v_inc;
  logic          h_in_sync, v_in_sync, h_active, v_active;

  // Tick is masked during Reset so nothing downstream sees a pixel advance
  // in the cycle the counters are being cleared.
  assign pixel_tick = En && !Reset && (presc_q == PRESC_LAST);
  assign v_inc      = pixel_tick & h_wrap;

  always_comb begin
    presc_d = presc_q;
    if (En) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end
    // Wraps only happen on a tick, so these are single-cycle by construction
    // and never stretched by the prescaler.
    line_end_d  = h_wrap;
    frame_end_d = h_wrap & v_wrap;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_q     <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  timing_axis_cnt #(
    .WIDTH      (CNT_W),
    .TOTAL      (H_TOTAL),
    .SYNC_START (`VGA_SYNC_START(H_ACTIVE, H_FP)),
    .SYNC_END   (`VGA_SYNC_END(H_ACTIVE, H_FP, H_SYNC)),
    .ACTIVE     (H_ACTIVE)
  ) u_h_axis (
    .clk     (Clk),
    .reset   (Reset),
    .en      (En),
    .inc     (pixel_tick),
    .cnt     (pixel_x),
    .wrap    (h_wrap),
    .in_sync (h_in_sync),
    .active  (h_active)
  );

  timing_axis_cnt #(
    .WIDTH      (CNT_W),
    .TOTAL      (V_TOTAL),
    .SYNC_START (`VGA_SYNC_START(V_ACTIVE, V_FP)),
    .SYNC_END   (`VGA_SYNC_END(V_ACTIVE, V_FP, V_SYNC)),
    .ACTIVE     (V_ACTIVE)
  ) u_v_axis (
    .clk     (Clk),
    .reset   (Reset),
    .en      (En),
    .inc     (v_inc),
    .cnt     (pixel_y),
    .wrap    (v_wrap),
    .in_sync (v_in_sync),
    .active  (v_active)
  );

  assign hsync     = sync_level(h_in_sync, HS_POL);
  assign vsync     = sync_level(v_in_sync, VS_POL);
  assign video_on  = h_active & v_active;
  assign line_end  = line_end_q & En;
  assign frame_end = frame_end_q & En;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (default, small and inverted-polarity setups)
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // DUT A: default 640x480 timing
  logic rst_a = 1'b1, en_a = 1'b0;
  logic [9:0] x_a, y_a;
  logic tick_a, hs_a, vs_a, vid_a, le_a, fe_a;

  vga_timing_gen dut_a (
    .Clk(clk), .Reset(rst_a), .En(en_a), .pixel_x(x_a), .pixel_y(y_a),
    .pixel_tick(tick_a), .hsync(hs_a), .vsync(vs_a), .video_on(vid_a),
    .line_end(le_a), .frame_end(fe_a)
  );

  // DUT B: CLK_DIV=1, H 8/1/2/1 (total 12), V 4/1/1/1 (total 7)
  logic rst_b = 1'b1, en_b = 1'b0;
  logic [3:0] x_b, y_b;
  logic tick_b, hs_b, vs_b, vid_b, le_b, fe_b;

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CNT_W(4)
  ) dut_b (
    .Clk(clk), .Reset(rst_b), .En(en_b), .pixel_x(x_b), .pixel_y(y_b),
    .pixel_tick(tick_b), .hsync(hs_b), .vsync(vs_b), .video_on(vid_b),
    .line_end(le_b), .frame_end(fe_b)
  );

  // DUT C: same small raster, CLK_DIV=2, active-high syncs
  logic rst_c = 1'b1, en_c = 1'b0;
  logic [3:0] x_c, y_c;
  logic tick_c, hs_c, vs_c, vid_c, le_c, fe_c;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
  ) dut_c (
    .Clk(clk), .Reset(rst_c), .En(en_c), .pixel_x(x_c), .pixel_y(y_c),
    .pixel_tick(tick_c), .hsync(hs_c), .vsync(vs_c), .video_on(vid_c),
    .line_end(le_c), .frame_end(fe_c)
  );

  // Scoreboard queues
  typedef struct { int x; int period; } fall_t;
  typedef struct { int x; int low; } rise_t;
  typedef struct { int y; int fe; int gap; int fgap; } line_t;

  fall_t qa_fall[$];
  rise_t qa_rise[$];
  line_t qb[$];

  // Monitor A: hsync edges
  logic a_hs_prev = 1'b1;
  int   a_last_fall = 0;
  always @(negedge clk) begin
    fall_t f;
    rise_t r;
    if (a_hs_prev === 1'b1 && hs_a === 1'b0) begin
      if (qa_fall.size() == 0) flag_fail("a_hsync_fall_unexpected");
      else begin
        f = qa_fall.pop_front();
        chk("a_fall_x", int'(x_a), f.x);
        if (f.period >= 0) chk("a_hsync_period", cyc - a_last_fall, f.period);
      end
      a_last_fall = cyc;
    end
    if (a_hs_prev === 1'b0 && hs_a === 1'b1) begin
      if (qa_rise.size() == 0) flag_fail("a_hsync_rise_unexpected");
      else begin
        r = qa_rise.pop_front();
        chk("a_rise_x", int'(x_a), r.x);
        chk("a_hsync_low", cyc - a_last_fall, r.low);
      end
    end
    a_hs_prev = hs_a;
  end

  // Monitor B: line_end / frame_end pulses
  int b_last_le = 0, b_last_fe = 0;
  always @(negedge clk) begin
    line_t e;
    if (le_b === 1'b1) begin
      if (qb.size() == 0) flag_fail("b_line_end_unexpected");
      else begin
        e = qb.pop_front();
        chk("b_le_x", int'(x_b), 0);
        chk("b_le_y", int'(y_b), e.y);
        chk("b_le_frame_end", int'(fe_b), e.fe);
        if (e.gap >= 0) chk("b_line_gap", cyc - b_last_le, e.gap);
        if (e.fgap >= 0) chk("b_frame_gap", cyc - b_last_fe, e.fgap);
      end
      b_last_le = cyc;
      if (fe_b === 1'b1) b_last_fe = cyc;
    end else if (fe_b === 1'b1) begin
      flag_fail("b_frame_end_without_line_end");
    end
  end

  initial begin
    fork
      // ---------------- DUT A ----------------
      begin
        int n;
        int pulses;
        rst_a = 1'b1; en_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("a_rst_x", int'(x_a), 0);
        chk("a_rst_y", int'(y_a), 0);
        chk("a_rst_hsync", int'(hs_a), 1);
        chk("a_rst_vsync", int'(vs_a), 1);
        chk("a_rst_video", int'(vid_a), 0);
        chk("a_rst_pulses", int'(le_a) + int'(fe_a) + int'(tick_a), 0);
        for (int i = 0; i < 3; i++) begin
          qa_fall.push_back('{x: 656, period: (i == 0) ? -1 : 1600});
          qa_rise.push_back('{x: 752, low: 192});
        end
        rst_a = 1'b0; en_a = 1'b1;
        @(negedge clk);
        chk("a_first_x", int'(x_a), 0);
        chk("a_first_video", int'(vid_a), 1);
        chk("a_first_hsync", int'(hs_a), 1);
        chk("a_first_tick", int'(tick_a), 1);
        n = 0;
        while (x_a != 10'd100 && n < 400) begin @(negedge clk); n++; end
        chk("a_reach_x100_timeout", int'(n < 400), 1);
        en_a = 1'b0;
        pulses = 0;
        repeat (50) begin
          @(negedge clk);
          chk("a_hold_x", int'(x_a), 100);
          pulses += int'(tick_a) + int'(le_a) + int'(fe_a);
        end
        chk("a_hold_pulses", pulses, 0);
        en_a = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (tick_a !== 1'b1 && n < 5);
        chk("a_resume_tick_timeout", int'(n < 5), 1);
        chk("a_resume_x_before", int'(x_a), 100);
        @(negedge clk);
        chk("a_resume_x", int'(x_a), 101);
        n = 0;
        while ((qa_fall.size() != 0 || qa_rise.size() != 0) && n < 8000) begin
          @(negedge clk); n++;
        end
        chk("a_hsync_timeout", int'(n < 8000), 1);
        rst_a = 1'b1;
      end
      // ---------------- DUT B ----------------
      begin
        int n;
        rst_b = 1'b1; en_b = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 19; k++) begin
          qb.push_back('{y: k % 7, fe: int'(k % 7 == 0), gap: (k == 1) ? -1 : 12,
                         fgap: (k == 14) ? 84 : -1});
        end
        rst_b = 1'b0; en_b = 1'b1;
        n = 0;
        while (qb.size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk("b_lines_timeout", int'(n < 400), 1);
        n = 0;
        while (!(x_b == 4'd10 && y_b == 4'd5) && n < 40) begin @(negedge clk); n++; end
        chk("b_reach_x10_timeout", int'(n < 40), 1);
        chk("b_mid_hsync", int'(hs_b), 0);
        chk("b_mid_vsync", int'(vs_b), 0);
        chk("b_mid_video", int'(vid_b), 0);
        rst_b = 1'b1;
        @(negedge clk);
        chk("b_rst_x", int'(x_b), 0);
        chk("b_rst_y", int'(y_b), 0);
        chk("b_rst_hsync", int'(hs_b), 1);
        chk("b_rst_vsync", int'(vs_b), 1);
        chk("b_rst_video", int'(vid_b), 0);
        chk("b_rst_pulses", int'(le_b) + int'(fe_b) + int'(tick_b), 0);
      end
      // ---------------- DUT C ----------------
      begin
        int n;
        rst_c = 1'b1; en_c = 1'b0;
        repeat (2) @(negedge clk);
        chk("c_rst_hsync", int'(hs_c), 0);
        chk("c_rst_vsync", int'(vs_c), 0);
        rst_c = 1'b0; en_c = 1'b1;
        @(negedge clk);
        chk("c_first_x", int'(x_c), 0);
        chk("c_first_video", int'(vid_c), 1);
        chk("c_first_hsync", int'(hs_c), 0);
        chk("c_first_tick", int'(tick_c), 1);
        @(negedge clk);
        chk("c_second_x", int'(x_c), 1);
        chk("c_second_tick", int'(tick_c), 0);
        n = 0;
        while (x_c != 4'd8 && n < 40) begin @(negedge clk); n++; end
        chk("c_reach_x8_timeout", int'(n < 40), 1);
        chk("c_x8_hsync", int'(hs_c), 0);
        chk("c_x8_video", int'(vid_c), 0);
        n = 0;
        while (x_c != 4'd9 && n < 40) begin @(negedge clk); n++; end
        chk("c_x9_hsync", int'(hs_c), 1);
        n = 0;
        while (y_c != 4'd5 && n < 200) begin @(negedge clk); n++; end
        chk("c_reach_y5_timeout", int'(n < 200), 1);
        chk("c_y5_vsync", int'(vs_c), 1);
        n = 0;
        while (y_c != 4'd6 && n < 40) begin @(negedge clk); n++; end
        chk("c_y6_vsync", int'(vs_c), 0);
        rst_c = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    chk("qa_fall_left", qa_fall.size(), 0);
    chk("qa_rise_left", qa_rise.size(), 0);
    chk("qb_left", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
